// File: rtl/car_game_pkg.sv
// Shared types and widths for the car game controller: FSM state codes,
// lane/score/frame-counter widths and the lane movement helper.
package car_game_pkg;

    localparam int unsigned LANE_W  = 2;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned CNT_W   = 20;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DRAW = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    // One lane step; opposing presses in the same cycle cancel out.
    function automatic logic [LANE_W-1:0] lane_next(
        input logic [LANE_W-1:0] cur,
        input logic              left,
        input logic              right,
        input logic [LANE_W-1:0] last
    );
        lane_next = cur;
        if (left && !right && cur != '0) begin
            lane_next = cur - LANE_W'(1);
        end else if (right && !left && cur != last) begin
            lane_next = cur + LANE_W'(1);
        end
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a level input. Stays quiet for the first cycle
// after reset so a level already high at release does not count as a press.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse_c
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= d;
            armed_q <= 1'b1;
        end
    end

    assign pulse_c = armed_q & d & ~prev_q;

endmodule

// File: rtl/car_game_ctrl.sv
// Car game control FSM: key edge detection, frame pacing, lane and score.
// Define CARGAME_SPEEDUP_EN to shorten the frame period every 16 points.
module car_game_ctrl
    import car_game_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 833333,
    parameter int unsigned TICK_MIN   = 416667,
    parameter int unsigned SPEED_STEP = 20833,
    parameter int unsigned LANES      = 3
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    input  logic               EnterEn,
    input  logic               LeftEn,
    input  logic               RightEn,
    input  logic               collision,
    input  logic               draw_done,
    output logic [1:0]         state,
    output logic [LANE_W-1:0]  lane,
    output logic               draw_req,
    output logic [SCORE_W-1:0] score,
    output logic               game_over
);

    localparam logic [LANE_W-1:0] LANE_INIT = LANE_W'(LANES / 2);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    // Out-of-range parameter sets elaborate this empty marker block.
    if (LANES < 2 || LANES > 4 || TICK_MIN > TICK_DIV || SPEED_STEP == 0 ||
        TICK_DIV > (1 << CNT_W)) begin : g_bad_params
    end

    logic enter_ev_c;
    logic left_ev_c;
    logic right_ev_c;

    edge_pulse u_enter (.clk(CLOCK_50), .rst_n(Resetn), .d(EnterEn), .pulse_c(enter_ev_c));
    edge_pulse u_left  (.clk(CLOCK_50), .rst_n(Resetn), .d(LeftEn),  .pulse_c(left_ev_c));
    edge_pulse u_right (.clk(CLOCK_50), .rst_n(Resetn), .d(RightEn), .pulse_c(right_ev_c));

    state_t             state_q, state_d;
    logic [LANE_W-1:0]  lane_d;
    logic [SCORE_W-1:0] score_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   frame_last_c;

`ifdef CARGAME_SPEEDUP_EN
    localparam logic [CNT_W:0] SHRINK_FLOOR = (CNT_W + 1)'(TICK_MIN + SPEED_STEP);

    logic [CNT_W-1:0] period_q, period_d;

    assign frame_last_c = period_q - CNT_W'(1);
`else
    assign frame_last_c = CNT_W'(TICK_DIV - 1);
`endif

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            lane      <= LANE_INIT;
            score     <= '0;
            cnt_q     <= '0;
            draw_req  <= 1'b0;
            game_over <= 1'b0;
`ifdef CARGAME_SPEEDUP_EN
            period_q  <= CNT_W'(TICK_DIV);
`endif
        end else begin
            state_q   <= state_d;
            lane      <= lane_d;
            score     <= score_d;
            cnt_q     <= cnt_d;
            draw_req  <= (state_d == ST_DRAW);
            game_over <= (state_d == ST_OVER);
`ifdef CARGAME_SPEEDUP_EN
            period_q  <= period_d;
`endif
        end
    end

    // Next-state logic; collision outranks frame expiry and draw_done.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane;
        score_d  = score;
        cnt_d    = cnt_q;
`ifdef CARGAME_SPEEDUP_EN
        period_d = period_q;
`endif
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (enter_ev_c) begin
                    state_d  = ST_PLAY;
                    lane_d   = LANE_INIT;
                    score_d  = '0;
                    cnt_d    = '0;
`ifdef CARGAME_SPEEDUP_EN
                    period_d = CNT_W'(TICK_DIV);
`endif
                end
            end
            ST_PLAY, ST_DRAW: begin
                lane_d = lane_next(lane, left_ev_c, right_ev_c, LANE_LAST);
                if (collision) begin
                    state_d = ST_OVER;
                end else if (state_q == ST_PLAY) begin
                    if (cnt_q == frame_last_c) begin
                        cnt_d   = '0;
                        state_d = ST_DRAW;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (draw_done) begin
                    state_d = ST_PLAY;
                    if (score != SCORE_MAX) begin
                        score_d = score + SCORE_W'(1);
`ifdef CARGAME_SPEEDUP_EN
                        if (score_d[3:0] == 4'd0) begin
                            period_d = ({1'b0, period_q} >= SHRINK_FLOOR) ?
                                       period_q - CNT_W'(SPEED_STEP) : CNT_W'(TICK_MIN);
                        end
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_car_game_ctrl.sv
// Self-checking bench for car_game_ctrl: directed scenarios then random play,
// compared every cycle against a behavioural game model.
module tb_car_game_ctrl;

    localparam int unsigned TICK_DIV   = 8;
    localparam int unsigned TICK_MIN   = 4;
    localparam int unsigned SPEED_STEP = 2;
    localparam int unsigned LANES      = 3;

    logic        CLOCK_50 = 1'b0;
    logic        Resetn;
    logic        EnterEn, LeftEn, RightEn, collision, draw_done;
    logic [1:0]  state, lane;
    logic        draw_req, game_over;
    logic [15:0] score;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model of the game
    int m_state, m_lane, m_score, m_cnt, m_period;
    bit m_fresh, m_pe, m_pl, m_pr;

    car_game_ctrl #(
        .TICK_DIV(TICK_DIV), .TICK_MIN(TICK_MIN),
        .SPEED_STEP(SPEED_STEP), .LANES(LANES)
    ) dut (
        .CLOCK_50(CLOCK_50), .Resetn(Resetn), .EnterEn(EnterEn),
        .LeftEn(LeftEn), .RightEn(RightEn), .collision(collision),
        .draw_done(draw_done), .state(state), .lane(lane),
        .draw_req(draw_req), .score(score), .game_over(game_over)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task model_reset();
        m_state  = 0;
        m_lane   = LANES / 2;
        m_score  = 0;
        m_cnt    = 0;
        m_period = TICK_DIV;
        m_fresh  = 1'b1;
        m_pe = 0; m_pl = 0; m_pr = 0;
    endtask

    task model_step(input bit e, input bit l, input bit r, input bit c, input bit d);
        bit ee, le, re;
        ee = !m_fresh && e && !m_pe;
        le = !m_fresh && l && !m_pl;
        re = !m_fresh && r && !m_pr;
        m_pe = e; m_pl = l; m_pr = r; m_fresh = 1'b0;
        if (m_state == 0 || m_state == 3) begin
            if (ee) begin
                m_state = 1; m_score = 0; m_cnt = 0;
                m_lane = LANES / 2; m_period = TICK_DIV;
            end
        end else begin
            if (le && !re && m_lane > 0) m_lane = m_lane - 1;
            if (re && !le && m_lane < LANES - 1) m_lane = m_lane + 1;
            if (c) begin
                m_state = 3;
            end else if (m_state == 1) begin
                if (m_cnt == m_period - 1) begin
                    m_cnt = 0; m_state = 2;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else if (d) begin
                m_state = 1;
                if (m_score < 65535) begin
                    m_score = m_score + 1;
`ifdef CARGAME_SPEEDUP_EN
                    if (m_score % 16 == 0) begin
                        m_period = (m_period - SPEED_STEP < TICK_MIN) ? TICK_MIN : m_period - SPEED_STEP;
                    end
`endif
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, {10'b0, state, lane, score, draw_req, game_over},
            {10'b0, 2'(m_state), 2'(m_lane), 16'(m_score), m_state == 2, m_state == 3});
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit e, input bit l, input bit r, input bit c, input bit d);
        EnterEn = e; LeftEn = l; RightEn = r; collision = c; draw_done = d;
        @(posedge CLOCK_50);
        model_step(e, l, r, c, d);
        #1;
        check_all("cycle");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic wait_draw(output int n);
        n = 0;
        while (!draw_req && n < 64) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        chk("wait_draw", 32'(draw_req), 32'd1);
    endtask

    // Asynchronous reset, optionally holding Enter through release.
    task automatic do_reset(input bit hold_enter);
        #2;
        EnterEn = hold_enter; LeftEn = 0; RightEn = 0; collision = 0; draw_done = 0;
        Resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_draw_req", 32'(draw_req), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        repeat (2) @(posedge CLOCK_50);
        #1;
        Resetn = 1'b1;
        step(hold_enter, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        int sc;
        bit ke, kl, kr;

        EnterEn = 0; LeftEn = 0; RightEn = 0; collision = 0; draw_done = 0;
        Resetn = 1'b1;
        model_reset();
        #3 Resetn = 1'b0;
        #20;
        check_all("reset_state");
        chk("reset_lane", 32'(lane), 32'd1);
        @(posedge CLOCK_50);
        #1 Resetn = 1'b1;
        step(0, 0, 0, 0, 0);

        // Start game and run first frame
        step(1, 0, 0, 0, 0);
        chk("start_state", 32'(state), 32'd1);
        chk("start_lane", 32'(lane), 32'd1);
        step(0, 0, 0, 0, 0);
        idle(7);
        chk("frame_draw_req", 32'(draw_req), 32'd1);
        step(0, 0, 0, 0, 1);
        chk("score_1", 32'(score), 32'd1);
        chk("back_to_play", 32'(state), 32'd1);
        for (int f = 0; f < 3; f++) begin
            idle(8);
            step(0, 0, 0, 0, 1);
        end
        chk("score_4", 32'(score), 32'd4);

        // Lane movement and saturation
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        chk("left_hold", 32'(lane), 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("left_floor", 32'(lane), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        chk("right_two", 32'(lane), 32'd2);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("right_ceiling", 32'(lane), 32'd2);
        step(0, 1, 1, 0, 0);
        chk("left_right_same", 32'(lane), 32'd2);

        // Collision beats draw_done, then restart
        wait_draw(n);
        sc = m_score;
        step(0, 0, 0, 1, 1);
        chk("over_state", 32'(state), 32'd3);
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_score_held", 32'(score), 32'(sc));
        step(1, 0, 0, 0, 0);
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_lane", 32'(lane), 32'd1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("enter_in_play", 32'(state), 32'd1);

        // Reset mid-DRAW, key held through release, stale draw_done
        wait_draw(n);
        do_reset(1'b1);
        step(1, 0, 0, 0, 1);
        chk("held_enter_no_event", 32'(state), 32'd0);
        chk("stale_draw_done", 32'(score), 32'd0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("enter_after_reset", 32'(state), 32'd1);

        // Random play against the model
        ke = 0; kl = 0; kr = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) ke = !ke;
            if ($urandom_range(0, 3) == 0) kl = !kl;
            if ($urandom_range(0, 3) == 0) kr = !kr;
            step(ke, kl, kr, $urandom_range(0, 63) == 0,
                 draw_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0));
        end

`ifdef CARGAME_SPEEDUP_EN
        // Frame period shrinks every 16 points and clamps at TICK_MIN
        do_reset(1'b0);
        step(1, 0, 0, 0, 0);
        for (int f = 0; f <= 48; f++) begin
            sc = m_score;
            wait_draw(n);
            if (sc == 0)  chk("period_start", 32'(n), 32'd8);
            if (sc == 16) chk("period_16", 32'(n), 32'd6);
            if (sc == 32) chk("period_32", 32'(n), 32'd4);
            if (sc == 48) chk("period_48", 32'(n), 32'd4);
            step(0, 0, 0, 0, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
